mem_access_unit: RTL and testbench

- MEM-stage engine; consumes the EX/MEM pipeline register outputs.
- Performs RV32I loads and stores over the byte-serial unified memory bus: 8-bit data, 1-cycle read latency.
- Holds the pipeline via stallreq_mem while an access is in flight.
- Presents the final register write-back triple to the MEM/WB register.

---
 rtl/mem_access_unit.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: serialises RV32I loads and stores onto an 8-bit,
// 1-cycle-latency memory bus and stalls the pipeline while an access is in flight.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            mem_wd_i,
  input  logic                  mem_wreg_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_store_data_i,
  input  logic [31:0]           mem_inst_i,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic [4:0]            wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stallreq_mem
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state, state_next;
  logic [2:0]  cnt;
  logic [31:0] load_buf;
  logic [2:0]  n_bytes;
  logic        is_signed;
  logic        is_store;

  // Instruction decode
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load_op;
  logic        is_store_op;
  logic        is_mem_op;
  logic [2:0]  dec_n;
  logic        dec_signed;

  assign opcode      = mem_inst_i[6:0];
  assign funct3      = mem_inst_i[14:12];
  assign is_load_op  = (opcode == OP_LOAD);
  assign is_store_op = (opcode == OP_STORE);
  assign is_mem_op   = is_load_op | is_store_op;
  assign dec_signed  = is_load_op & ~funct3[2];

  // Only LB/LH/LW/LBU/LHU and SB/SH/SW are defined; every other funct3 is a word access.
  always_comb begin
    case (funct3)
      3'b000:  dec_n = 3'd1;
      3'b001:  dec_n = 3'd2;
      3'b100:  dec_n = is_load_op ? 3'd1 : 3'd4;
      3'b101:  dec_n = is_load_op ? 3'd2 : 3'd4;
      default: dec_n = 3'd4;
    endcase
  end

  // Byte address and data lanes for the current ACCESS cycle
  logic [31:0] addr_k;
  logic [2:0]  cnt_m1;
  logic [7:0]  store_byte;

  assign addr_k     = mem_addr_i + {29'd0, cnt};
  assign cnt_m1     = cnt - 3'd1;
  assign store_byte = mem_store_data_i[{cnt[1:0], 3'b000} +: 8];

  logic unused_bits;
  assign unused_bits = ^{mem_inst_i[31:15], mem_inst_i[11:7], cnt_m1[2], addr_k};

  // Width/sign extension of the assembled load value
  logic [31:0] load_ext;

  always_comb begin
    case (n_bytes)
      3'd1:    load_ext = {{24{is_signed & load_buf[7]}}, load_buf[7:0]};
      3'd2:    load_ext = {{16{is_signed & load_buf[15]}}, load_buf[15:0]};
      default: load_ext = load_buf;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      load_buf  <= 32'd0;
      n_bytes   <= 3'd0;
      is_signed <= 1'b0;
      is_store  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (is_mem_op) begin
            n_bytes   <= dec_n;
            is_signed <= dec_signed;
            is_store  <= is_store_op;
            cnt       <= 3'd0;
            load_buf  <= 32'd0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 3'd1;
          // Read data lags its address by one cycle, so cycle k delivers byte k-1.
          if (!is_store && cnt != 3'd0) begin
            load_buf[{cnt_m1[1:0], 3'b000} +: 8] <= mem_din;
          end
        end
        default: begin
          cnt <= 3'd0;
        end
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    state_next = state;
    case (state)
      IDLE: begin
        if (is_mem_op) state_next = ACCESS;
      end
      ACCESS: begin
        if (is_store) begin
          if (cnt == n_bytes - 3'd1) state_next = DONE;
        end else begin
          if (cnt == n_bytes) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus and write-back outputs
  always_comb begin
    mem_a        = '0;
    mem_dout     = 8'd0;
    mem_wr       = 1'b0;
    stallreq_mem = 1'b0;
    wd_o         = mem_wd_i;
    wreg_o       = mem_wreg_i;
    wdata_o      = mem_wdata_i;
    if (rst) begin
      wd_o    = 5'd0;
      wreg_o  = 1'b0;
      wdata_o = 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem_op) begin
            stallreq_mem = 1'b1;
            wreg_o       = 1'b0;
            wdata_o      = 32'd0;
          end
        end
        ACCESS: begin
          stallreq_mem = 1'b1;
          wreg_o       = 1'b0;
          wdata_o      = 32'd0;
          if (cnt < n_bytes) begin
            mem_a  = addr_k[ADDR_WIDTH-1:0];
            mem_wr = is_store;
            if (is_store) mem_dout = store_byte;
          end
        end
        DONE: begin
          if (!is_store) wdata_o = load_ext;
        end
        default: begin
          wreg_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a byte-wide,
// one-cycle-latency memory model.
module tb_mem_access_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_store_data_i;
  logic [31:0] mem_inst_i;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_mem;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_wd_i         (mem_wd_i),
    .mem_wreg_i       (mem_wreg_i),
    .mem_wdata_i      (mem_wdata_i),
    .mem_addr_i       (mem_addr_i),
    .mem_store_data_i (mem_store_data_i),
    .mem_inst_i       (mem_inst_i),
    .mem_din          (mem_din),
    .mem_dout         (mem_dout),
    .mem_a            (mem_a),
    .mem_wr           (mem_wr),
    .wd_o             (wd_o),
    .wreg_o           (wreg_o),
    .wdata_o          (wdata_o),
    .stallreq_mem     (stallreq_mem)
  );

  // Memory model indexed by the low 12 address bits; unwritten bytes come from a preload table.
  bit [7:0] mem_model [0:4095];
  bit       written   [0:4095];

  function automatic logic [7:0] init_byte(input logic [11:0] a);
    case (a)
      12'h010: return 8'h80;
      12'h020: return 8'h00;
      12'h021: return 8'h80;
      12'h200: return 8'h78;
      12'h201: return 8'h56;
      12'h202: return 8'h34;
      12'h203: return 8'h12;
      12'hFFE: return 8'h11;
      12'h001: return 8'h22;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_wr) begin
      mem_model[mem_a[11:0]] <= mem_dout;
      written[mem_a[11:0]]   <= 1'b1;
    end
    mem_din <= written[mem_a[11:0]] ? mem_model[mem_a[11:0]] : init_byte(mem_a[11:0]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_inputs(input logic [31:0] inst, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [4:0] wd,
                            input logic wreg, input logic [31:0] wdata);
    mem_inst_i       = inst;
    mem_addr_i       = addr;
    mem_store_data_i = sdata;
    mem_wd_i         = wd;
    mem_wreg_i       = wreg;
    mem_wdata_i      = wdata;
  endtask

  // Applies one memory instruction in the current (IDLE) cycle and follows it through DONE.
  task automatic mem_op(input string name, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] wd, input logic wreg, input int n,
                        input int exp_stall, input logic [31:0] exp_wdata);
    bit   st;
    int   stalls;
    logic [31:0] exp_byte;
    st = (op == OP_STORE);
    set_inputs({17'd0, f3, 5'd0, op}, addr, sdata, wd, wreg, addr);
    #1;
    check({name, "_idle_stall"}, 32'(stallreq_mem), 32'd1);
    check({name, "_idle_wreg"}, 32'(wreg_o), 32'd0);
    stalls = stallreq_mem ? 1 : 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (!stallreq_mem) break;
      stalls++;
      if (k < n) begin
        check({name, "_addr"}, mem_a, addr + 32'(k));
        check({name, "_wr"}, 32'(mem_wr), 32'(st));
        if (st) begin
          exp_byte = (sdata >> (8 * k)) & 32'hFF;
          check({name, "_dout"}, 32'(mem_dout), exp_byte);
        end
      end else begin
        check({name, "_addr_last"}, mem_a, 32'd0);
      end
    end
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({name, "_done_wdata"}, wdata_o, exp_wdata);
    check({name, "_done_wreg"}, 32'(wreg_o), 32'(wreg));
    check({name, "_done_wd"}, 32'(wd_o), 32'(wd));
    check({name, "_done_wr"}, 32'(mem_wr), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_inputs(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    repeat (2) tick;
    check("rst_stall", 32'(stallreq_mem), 32'd0);
    check("rst_a", mem_a, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_stall", 32'(stallreq_mem), 32'd0);
    check("post_rst_wr", 32'(mem_wr), 32'd0);
    check("post_rst_wreg", 32'(wreg_o), 32'd0);

    // ADDI x3, x0, 5 passes straight through in the same cycle
    tick;
    set_inputs(32'h00500193, 32'd0, 32'd0, 5'd3, 1'b1, 32'h00000005);
    #1;
    check("addi_wdata", wdata_o, 32'h00000005);
    check("addi_wd", 32'(wd_o), 32'd3);
    check("addi_wreg", 32'(wreg_o), 32'd1);
    check("addi_stall", 32'(stallreq_mem), 32'd0);
    check("addi_wr", 32'(mem_wr), 32'd0);

    tick;
    mem_op("sw",  OP_STORE, 3'b010, 32'h00000100, 32'hDEADBEEF, 5'd7, 1'b0, 4, 5, 32'h00000100);
    tick;
    mem_op("lw",  OP_LOAD,  3'b010, 32'h00000200, 32'd0,        5'd5, 1'b1, 4, 6, 32'h12345678);
    tick;
    mem_op("lb",  OP_LOAD,  3'b000, 32'h00000010, 32'd0,        5'd6, 1'b1, 1, 3, 32'hFFFFFF80);
    tick;
    mem_op("lbu", OP_LOAD,  3'b100, 32'h00000010, 32'd0,        5'd6, 1'b1, 1, 3, 32'h00000080);
    tick;
    mem_op("lh",  OP_LOAD,  3'b001, 32'h00000020, 32'd0,        5'd8, 1'b1, 2, 4, 32'hFFFF8000);
    tick;
    mem_op("lhu", OP_LOAD,  3'b101, 32'h00000020, 32'd0,        5'd8, 1'b1, 2, 4, 32'h00008000);
    tick;
    mem_op("sh_wrap", OP_STORE, 3'b001, 32'hFFFFFFFF, 32'h0000AABB, 5'd9, 1'b0, 2, 3, 32'hFFFFFFFF);
    check("sh_mem_fff", 32'(mem_model[12'hFFF]), 32'h000000BB);
    check("sh_mem_000", 32'(mem_model[12'h000]), 32'h000000AA);
    // Back-to-back: the load is applied right at the DONE->IDLE edge
    tick;
    mem_op("lw_wrap", OP_LOAD, 3'b010, 32'hFFFFFFFE, 32'd0,     5'd10, 1'b1, 4, 6, 32'h22AABB11);

    // Reset in the middle of an LW at cnt=2
    tick;
    set_inputs({17'd0, 3'b010, 5'd0, OP_LOAD}, 32'h00000300, 32'd0, 5'd4, 1'b1, 32'h00000300);
    repeat (3) tick;
    check("midrst_addr", mem_a, 32'h00000302);
    rst = 1'b1;
    #1;
    check("midrst_stall_in_rst", 32'(stallreq_mem), 32'd0);
    repeat (2) tick;
    rst = 1'b0;
    set_inputs(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    #1;
    check("midrst_stall", 32'(stallreq_mem), 32'd0);
    check("midrst_wr", 32'(mem_wr), 32'd0);
    check("midrst_a", mem_a, 32'd0);
    check("midrst_wreg", 32'(wreg_o), 32'd0);
    tick;
    set_inputs(32'h00500193, 32'd0, 32'd0, 5'd3, 1'b1, 32'h0000002A);
    #1;
    check("midrst_idle_pass", wdata_o, 32'h0000002A);
    check("midrst_idle_stall", 32'(stallreq_mem), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
